// File: rtl/fifo_flagged.sv
// Parameterised synchronous FIFO with occupancy count, programmable almost-full/empty
// thresholds, sticky error flags, synchronous flush and selectable FWFT/registered read.
module fifo_flagged #(
    parameter int DATA_SIZE      = 16,
    parameter int ADDR_SPACE_EXP = 10,
    parameter int AF_THRESH      = (1 << ADDR_SPACE_EXP) - 4,
    parameter int AE_THRESH      = 4,
    parameter int FWFT           = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      wr_en,
    input  logic [DATA_SIZE-1:0]      wr_data,
    input  logic                      rd_en,
    output logic [DATA_SIZE-1:0]      rd_data,
    output logic                      rd_valid,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [ADDR_SPACE_EXP:0]   count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int                    AW      = ADDR_SPACE_EXP;
    localparam int                    CW      = ADDR_SPACE_EXP + 1;
    localparam int                    DEPTH   = 1 << ADDR_SPACE_EXP;
    localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]         AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0]         AE_C    = CW'(AE_THRESH);
    localparam logic                  AF_RST  = (AF_THRESH == 0);

    logic [DATA_SIZE-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 r_full;
    logic                 r_empty;
    logic                 r_almost_full;
    logic                 r_almost_empty;
    logic                 r_overflow;
    logic                 r_underflow;

    logic                 w_rd_acc;
    logic                 w_wr_acc;
    logic [CW-1:0]        w_count_nxt;

    // A read at full frees a slot in the same cycle, so the write is still taken.
    always_comb begin
        w_rd_acc    = rd_en & ~r_empty;
        w_wr_acc    = wr_en & (~r_full | w_rd_acc);
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc)
            w_count_nxt = r_count + CW'(1);
        else if (w_rd_acc && !w_wr_acc)
            w_count_nxt = r_count - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= AF_RST;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else if (flush) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= AF_RST;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_wr_acc)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_acc)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == DEPTH_C);
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= AF_C);
            r_almost_empty <= (w_count_nxt <= AE_C);
            r_overflow     <= r_overflow | (wr_en & ~w_wr_acc);
            r_underflow    <= r_underflow | (rd_en & r_empty);
        end
    end

    // Storage is never cleared; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !flush && !reset)
            r_mem[r_wr_ptr] <= wr_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data  = r_mem[r_rd_ptr];
            assign rd_valid = ~r_empty;
        end else begin : g_registered
            logic [DATA_SIZE-1:0] r_rd_data;
            logic                 r_rd_valid;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else if (flush) begin
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc)
                        r_rd_data <= r_mem[r_rd_ptr];
                end
            end

            assign rd_data  = r_rd_data;
            assign rd_valid = r_rd_valid;
        end
    endgenerate

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
